// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp_pkg
// Description : Shared types and constants for the multi-port register file.
//               - clr_state_t : clear-engine state encoding (IDLE / SWEEP)
//               - kRegDepth   : entry count of the default configuration
//                               (2**D with D = 4)
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_mp_pkg;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

    localparam int kRegDepth = 16;

endpackage : reg_file_mp_pkg
`default_nettype wire

// File: rtl/reg_file_mp_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_clear_seq
// Description : Sequenced clear engine. It zeroes one register-file entry
//               per cycle, from entry 0 to entry 2**D-1, without a global
//               reset.
// Ports       : CLK        - clock, rising edge
//               reset      - asynchronous active-high reset (returns to IDLE)
//               clear_req  - single-cycle request to start a sweep
//               busy       - high for exactly 2**D cycles while sweeping
//               sweep_we   - write strobe to the array (zero the entry)
//               sweep_addr - entry being zeroed this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module reg_clear_seq #(
    parameter int D = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         clear_req,
    output logic         busy,
    output logic         sweep_we,
    output logic [D-1:0] sweep_addr
);
    import reg_file_mp_pkg::*;

    localparam logic [0:0]   S_IDLE  = CLR_IDLE;
    localparam logic [0:0]   S_SWEEP = CLR_SWEEP;
    localparam logic [D-1:0] c_last  = '1;

    logic [0:0]   r_state;
    logic [D-1:0] r_ptr;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_state <= S_SWEEP;
                        r_ptr   <= '0;
                    end
                end
                S_SWEEP: begin
                    // A new clear_req is ignored here. The pointer wraps to 0
                    // on the same edge that zeroes the last entry.
                    r_ptr <= r_ptr + D'(1);
                    if (r_ptr == c_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Every output comes straight from a flop, so no input reaches busy
    // through combinational logic.
    assign busy       = (r_state == S_SWEEP);
    assign sweep_we   = busy;
    assign sweep_addr = r_ptr;

endmodule : reg_clear_seq
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised multi-port register file. It has NR
//               combinational read ports, two prioritised write ports
//               (A wins), optional write-through bypass, an optional
//               hard-wired zero entry and a sequenced clear engine.
// Ports       : CLK, reset                  - clock / async active-high reset
//               we_a, waddr_a, wdata_a      - write port A (high priority)
//               we_b, waddr_b, wdata_b      - write port B (low priority)
//               raddr[NR*D], rdata[NR*W]    - packed read ports
//               clear_req, busy             - sweep clear request / status
//               collision                   - pulse: A and B hit same entry
//               wr_drop                     - pulse: write dropped while busy
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int NR      = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            we_a,
    input  logic [D-1:0]    waddr_a,
    input  logic [W-1:0]    wdata_a,
    input  logic            we_b,
    input  logic [D-1:0]    waddr_b,
    input  logic [W-1:0]    wdata_b,
    input  logic [NR*D-1:0] raddr,
    output logic [NR*W-1:0] rdata,
    input  logic            clear_req,
    output logic            busy,
    output logic            collision,
    output logic            wr_drop
);
    import reg_file_mp_pkg::*;

    localparam int c_depth = 2 ** D;

    logic [W-1:0] r_mem [c_depth];
    logic         r_collision;
    logic         r_wr_drop;

    logic         w_busy;
    logic         w_sweep_we;
    logic [D-1:0] w_sweep_addr;
    logic         w_a_zero;
    logic         w_b_zero;
    logic         w_a_live;
    logic         w_b_live;
    logic         w_same;
    logic         w_a_eff;
    logic         w_b_eff;
    logic         w_coll;
    logic         w_drop;

    reg_clear_seq #(
        .D          (D)
    ) u_clear_seq (
        .CLK        (CLK),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (w_busy),
        .sweep_we   (w_sweep_we),
        .sweep_addr (w_sweep_addr)
    );

    // A write to a hard-wired zero entry does nothing. It never counts as a
    // collision or as a drop.
    assign w_a_zero = (ZERO_R0 != 0) && (waddr_a == '0);
    assign w_b_zero = (ZERO_R0 != 0) && (waddr_b == '0);
    assign w_a_live = we_a && !w_a_zero;
    assign w_b_live = we_b && !w_b_zero;
    assign w_same   = (waddr_a == waddr_b);

    // While the sweep runs, all user writes are dropped. So sweep and user
    // writes never target the array on the same edge.
    assign w_a_eff = w_a_live && !w_busy;
    assign w_b_eff = w_b_live && !w_busy && !(w_a_live && w_same);
    assign w_coll  = w_a_live && w_b_live && w_same && !w_busy;
    assign w_drop  = w_busy && (w_a_live || w_b_live);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_sweep_we) begin
                r_mem[w_sweep_addr] <= '0;
            end
            if (w_b_eff) begin
                r_mem[waddr_b] <= wdata_b;
            end
            if (w_a_eff) begin
                r_mem[waddr_a] <= wdata_a;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_collision <= 1'b0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_collision <= w_coll;
            r_wr_drop   <= w_drop;
        end
    end

    // Each read port has its own decode. Ports may alias one another.
    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
        logic [D-1:0] w_ra;
        logic         w_ra_zero;
        logic [W-1:0] w_stored;
        logic [W-1:0] w_out;

        assign w_ra      = raddr[gi*D +: D];
        assign w_ra_zero = (ZERO_R0 != 0) && (w_ra == '0);
        assign w_stored  = w_ra_zero ? '0 : r_mem[w_ra];

        if (BYPASS != 0) begin : g_byp
            // Only effective writes are forwarded. A is checked first, so
            // on a collision the read returns A's data. The effective-write
            // flags already exclude entry 0 when it is hard-wired.
            assign w_out = (w_a_eff && (waddr_a == w_ra)) ? wdata_a :
                           (w_b_eff && (waddr_b == w_ra)) ? wdata_b :
                           w_stored;
        end else begin : g_nobyp
            assign w_out = w_stored;
        end

        assign rdata[gi*W +: W] = w_out;
    end

    assign busy      = w_busy;
    assign collision = r_collision;
    assign wr_drop   = r_wr_drop;

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Directed self-checking bench for reg_file_mp. It uses two
//               instances:
//               - default configuration (NR=2, BYPASS=1, ZERO_R0=0)
//               - NR=4, BYPASS=0, ZERO_R0=1
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;
    import reg_file_mp_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic        we_a, we_b;
    logic [3:0]  waddr_a, waddr_b;
    logic [7:0]  wdata_a, wdata_b;
    logic [7:0]  raddr;
    logic [15:0] rdata;
    logic        clear_req, busy, collision, wr_drop;

    logic        z_we_a, z_we_b;
    logic [3:0]  z_waddr_a, z_waddr_b;
    logic [7:0]  z_wdata_a, z_wdata_b;
    logic [15:0] z_raddr;
    logic [31:0] z_rdata;
    logic        z_clear_req, z_busy, z_collision, z_wr_drop;

    int nvec = 0;
    int nmis = 0;

    always #5 CLK = ~CLK;

    reg_file_mp #(.W(8), .D(4), .NR(2), .BYPASS(1), .ZERO_R0(0)) dut (
        .CLK(CLK), .reset(reset),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
        .raddr(raddr), .rdata(rdata),
        .clear_req(clear_req), .busy(busy),
        .collision(collision), .wr_drop(wr_drop)
    );

    reg_file_mp #(.W(8), .D(4), .NR(4), .BYPASS(0), .ZERO_R0(1)) dut_z (
        .CLK(CLK), .reset(reset),
        .we_a(z_we_a), .waddr_a(z_waddr_a), .wdata_a(z_wdata_a),
        .we_b(z_we_b), .waddr_b(z_waddr_b), .wdata_b(z_wdata_b),
        .raddr(z_raddr), .rdata(z_rdata),
        .clear_req(z_clear_req), .busy(z_busy),
        .collision(z_collision), .wr_drop(z_wr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        we_a = 0; we_b = 0; waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0;
        raddr = 0; clear_req = 0;
        z_we_a = 0; z_we_b = 0; z_waddr_a = 0; z_waddr_b = 0;
        z_wdata_a = 0; z_wdata_b = 0; z_raddr = 0; z_clear_req = 0;
        step(); step();
        reset = 1'b0;
        step();

        // Preload every entry with FF, then apply reset with no clock edge
        for (int k = 0; k < 8; k++) begin
            we_a = 1; waddr_a = 4'(k);     wdata_a = 8'hFF;
            we_b = 1; waddr_b = 4'(k + 8); wdata_b = 8'hFF;
            step();
        end
        we_a = 0; we_b = 0;
        raddr = {4'd15, 4'd0};
        #1;
        chk("preload_e0", {24'h0, rdata[7:0]}, 32'hFF);
        chk("preload_e15", {24'h0, rdata[15:8]}, 32'hFF);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            raddr = {4'(15 - i), 4'(i)};
            #1;
            chk("reset_p0", {24'h0, rdata[7:0]}, 32'h0);
            chk("reset_p1", {24'h0, rdata[15:8]}, 32'h0);
        end
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_coll", {31'h0, collision}, 32'h0);
        chk("reset_drop", {31'h0, wr_drop}, 32'h0);
        reset = 1'b0;
        step();

        // Two writes to different addresses in one cycle
        we_a = 1; waddr_a = 4'd3; wdata_a = 8'h5A;
        we_b = 1; waddr_b = 4'd7; wdata_b = 8'hC3;
        raddr = {4'd7, 4'd3};
        #1;
        chk("byp_a", {24'h0, rdata[7:0]}, 32'h5A);
        chk("byp_b", {24'h0, rdata[15:8]}, 32'hC3);
        step();
        we_a = 0; we_b = 0;
        #1;
        chk("diff_a", {24'h0, rdata[7:0]}, 32'h5A);
        chk("diff_b", {24'h0, rdata[15:8]}, 32'hC3);
        chk("diff_coll", {31'h0, collision}, 32'h0);

        // Both ports write the same address: A wins
        we_a = 1; waddr_a = 4'd5; wdata_a = 8'h11;
        we_b = 1; waddr_b = 4'd5; wdata_b = 8'h22;
        raddr = {4'd5, 4'd5};
        #1;
        chk("coll_byp_p0", {24'h0, rdata[7:0]}, 32'h11);
        chk("coll_byp_p1", {24'h0, rdata[15:8]}, 32'h11);
        step();
        we_a = 0; we_b = 0;
        #1;
        chk("coll_store", {24'h0, rdata[7:0]}, 32'h11);
        chk("coll_pulse", {31'h0, collision}, 32'h1);
        step();
        chk("coll_clear", {31'h0, collision}, 32'h0);

        // Entry m holds m+1, then a sweep clears them
        for (int k = 0; k < 8; k++) begin
            we_a = 1; waddr_a = 4'(k);     wdata_a = 8'(k + 1);
            we_b = 1; waddr_b = 4'(k + 8); wdata_b = 8'(k + 9);
            step();
        end
        we_a = 0; we_b = 0;
        clear_req = 1;
        #1;
        chk("busy_not_comb", {31'h0, busy}, 32'h0);
        step();
        clear_req = 0;
        for (int j = 0; j < 16; j++) begin
            raddr[3:0] = 4'(j);
            raddr[7:4] = (j == 3) ? 4'd12 : 4'(j - 1);
            if (j == 2) begin
                we_a = 1; waddr_a = 4'd12; wdata_a = 8'hEE;
            end
            if (j == 5) clear_req = 1;
            #1;
            chk("sweep_busy", {31'h0, busy}, 32'h1);
            chk("sweep_old", {24'h0, rdata[7:0]}, 32'(j + 1));
            if (j == 3) begin
                chk("drop_entry", {24'h0, rdata[15:8]}, 32'h0D);
                chk("drop_pulse", {31'h0, wr_drop}, 32'h1);
                chk("drop_nocoll", {31'h0, collision}, 32'h0);
            end else if (j > 0) begin
                chk("sweep_zero", {24'h0, rdata[15:8]}, 32'h0);
            end
            if (j == 4) chk("drop_clear", {31'h0, wr_drop}, 32'h0);
            step();
            we_a = 0; clear_req = 0;
        end
        #1;
        chk("sweep_done", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            raddr = {4'(i + 8), 4'(i)};
            #1;
            chk("post_sweep_lo", {24'h0, rdata[7:0]}, 32'h0);
            chk("post_sweep_hi", {24'h0, rdata[15:8]}, 32'h0);
        end

        // Reset at sweep cycle 6 aborts the sweep
        we_a = 1; waddr_a = 4'd9;  wdata_a = 8'h99;
        we_b = 1; waddr_b = 4'd14; wdata_b = 8'hAB;
        step();
        we_a = 0; we_b = 0;
        clear_req = 1;
        step();
        clear_req = 0;
        for (int j = 0; j < 6; j++) step();
        raddr = {4'd14, 4'd9};
        #1;
        chk("pre_abort_e9", {24'h0, rdata[7:0]}, 32'h99);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_e9", {24'h0, rdata[7:0]}, 32'h0);
        chk("abort_e14", {24'h0, rdata[15:8]}, 32'h0);
        reset = 1'b0;
        step();

        // A fresh sweep starts at entry 0 and lasts 16 cycles
        we_a = 1; waddr_a = 4'd0; wdata_a = 8'h42;
        step();
        we_a = 0;
        clear_req = 1;
        step();
        clear_req = 0;
        raddr = {4'd0, 4'd0};
        #1;
        chk("restart_busy", {31'h0, busy}, 32'h1);
        chk("restart_e0_old", {24'h0, rdata[7:0]}, 32'h42);
        step();
        chk("restart_e0_zero", {24'h0, rdata[7:0]}, 32'h0);
        n = 2;
        for (int g = 0; g < 40 && busy; g++) begin
            step();
            if (busy) n++;
        end
        chk("busy_len", 32'(n), 32'(kRegDepth));

        // Hard-wired zero entry (NR=4, no bypass)
        z_we_a = 1; z_waddr_a = 4'd0; z_wdata_a = 8'h77;
        z_we_b = 1; z_waddr_b = 4'd0; z_wdata_b = 8'h55;
        z_raddr = 16'h0000;
        #1;
        for (int i = 0; i < 4; i++) chk("z_same_cycle", {24'h0, z_rdata[i*8 +: 8]}, 32'h0);
        step();
        z_we_a = 0; z_we_b = 0;
        #1;
        for (int i = 0; i < 4; i++) chk("z_r0", {24'h0, z_rdata[i*8 +: 8]}, 32'h0);
        chk("z_coll", {31'h0, z_collision}, 32'h0);
        chk("z_drop", {31'h0, z_wr_drop}, 32'h0);
        z_we_a = 1; z_waddr_a = 4'd1; z_wdata_a = 8'h66;
        z_raddr = 16'h0001;
        #1;
        chk("z_nobyp", {24'h0, z_rdata[7:0]}, 32'h0);
        step();
        z_we_a = 0;
        #1;
        chk("z_e1", {24'h0, z_rdata[7:0]}, 32'h66);
        chk("z_busy", {31'h0, z_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_reg_file_mp
`default_nettype wire
